// File: rtl/cs_rx_assembler_2_3.sv
// rtl/cs_rx_assembler_2_3.sv - collects the three coded symbols of one generation for the (2,3) decoder
module cs_rx_assembler_2_3 #(
    parameter int WIDTH   = 4,
    parameter int GEN_W   = 4,
    parameter int TIMEOUT = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             sym_valid,
    output logic             sym_ready,
    input  logic [1:0]       sym_idx,
    input  logic [GEN_W-1:0] sym_gen,
    input  logic [WIDTH-1:0] sym_data,
    output logic             valid_out,
    output logic [2:0]       erasure,
    output logic [WIDTH-1:0] coded_0,
    output logic [WIDTH-1:0] coded_1,
    output logic [WIDTH-1:0] coded_2,
    output logic [GEN_W-1:0] gen_out,
    output logic [7:0]       drop_cnt
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COLLECT = 2'd1,
        EMIT    = 2'd2
    } state_t;

    // Last COLLECT cycle before a partial set is forced out.
    localparam logic [7:0] TIMER_LAST = 8'(TIMEOUT - 1);

    state_t                  state_q, state_d;
    logic [GEN_W-1:0]        cur_gen_q, cur_gen_d;
    logic [2:0][WIDTH-1:0]   slot_q, slot_d;
    logic [2:0]              rcv_q, rcv_d;
    logic [7:0]              timer_q, timer_d;
    logic                    seen_q, seen_d;
    logic [7:0]              drop_cnt_q, drop_cnt_d;
    logic                    valid_q, valid_d;
    logic [2:0]              erasure_q, erasure_d;
    logic [2:0][WIDTH-1:0]   coded_q, coded_d;
    logic [GEN_W-1:0]        gen_out_q, gen_out_d;
    logic                    drop;

    // State and output registers; reset discards any partial generation.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            cur_gen_q  <= '0;
            slot_q     <= '0;
            rcv_q      <= '0;
            timer_q    <= '0;
            seen_q     <= 1'b0;
            drop_cnt_q <= '0;
            valid_q    <= 1'b0;
            erasure_q  <= '0;
            coded_q    <= '0;
            gen_out_q  <= '0;
        end else begin
            state_q    <= state_d;
            cur_gen_q  <= cur_gen_d;
            slot_q     <= slot_d;
            rcv_q      <= rcv_d;
            timer_q    <= timer_d;
            seen_q     <= seen_d;
            drop_cnt_q <= drop_cnt_d;
            valid_q    <= valid_d;
            erasure_q  <= erasure_d;
            coded_q    <= coded_d;
            gen_out_q  <= gen_out_d;
        end
    end

    // Next-state, symbol acceptance and emission capture.
    always_comb begin
        state_d    = state_q;
        cur_gen_d  = cur_gen_q;
        slot_d     = slot_q;
        rcv_d      = rcv_q;
        timer_d    = timer_q;
        seen_d     = seen_q;
        drop_cnt_d = drop_cnt_q;
        valid_d    = 1'b0;
        erasure_d  = erasure_q;
        coded_d    = coded_q;
        gen_out_d  = gen_out_q;
        sym_ready  = 1'b0;
        drop       = 1'b0;

        case (state_q)
            IDLE: begin
                sym_ready = 1'b1;
                if (sym_valid) begin
                    // Illegal slot or a late copy of the set just emitted.
                    if (sym_idx == 2'd3 || (seen_q && sym_gen == gen_out_q)) begin
                        drop = 1'b1;
                    end else begin
                        cur_gen_d        = sym_gen;
                        slot_d[sym_idx]  = sym_data;
                        rcv_d            = 3'b001 << sym_idx;
                        timer_d          = '0;
                        state_d          = COLLECT;
                    end
                end
            end
            COLLECT: begin
                sym_ready = (sym_gen == cur_gen_q);
                timer_d   = timer_q + 8'd1;
                if (sym_valid && sym_ready) begin
                    if (sym_idx == 2'd3 || rcv_q[sym_idx]) begin
                        drop = 1'b1;
                    end else begin
                        slot_d[sym_idx] = sym_data;
                        rcv_d[sym_idx]  = 1'b1;
                    end
                end
                // Complete set, timeout, or a newer generation forcing a flush.
                if (rcv_q == 3'b111 || timer_q == TIMER_LAST || (sym_valid && !sym_ready)) begin
                    state_d    = EMIT;
                    valid_d    = 1'b1;
                    erasure_d  = ~rcv_d;
                    coded_d[0] = rcv_d[0] ? slot_d[0] : '0;
                    coded_d[1] = rcv_d[1] ? slot_d[1] : '0;
                    coded_d[2] = rcv_d[2] ? slot_d[2] : '0;
                    gen_out_d  = cur_gen_q;
                    seen_d     = 1'b1;
                end
            end
            EMIT: begin
                state_d = IDLE;
                rcv_d   = '0;
            end
            default: begin
                state_d = IDLE;
                rcv_d   = '0;
            end
        endcase

        if (drop && drop_cnt_q != 8'hFF) begin
            drop_cnt_d = drop_cnt_q + 8'd1;
        end
    end

    assign valid_out = valid_q;
    assign erasure   = erasure_q;
    assign coded_0   = coded_q[0];
    assign coded_1   = coded_q[1];
    assign coded_2   = coded_q[2];
    assign gen_out   = gen_out_q;
    assign drop_cnt  = drop_cnt_q;

endmodule
